ps2_arrow_decoder: RTL and testbench
====================================

Name: ps2_arrow_decoder

Overview:
- Receives raw PS/2 keyboard frames and decodes the four arrow keys into level-held direction signals.
- The four outputs mv_left, mv_right, mv_down and mv_up replace the active-low KEY pushbuttons at the input of the game control FSM.
- Synchronises and filters the PS/2 clock, deserialises 11-bit frames, checks parity, and tracks make/break/extended scan-code sequences.

Parameters:
- FILTER_LEN, 4: consecutive identical samples of synchronised ps2_clk required before its filtered level changes.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered ps2_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock line, asynchronous
- ps2_dat  in  1  raw PS/2 data line, asynchronous
- mv_left  out  1  high while left arrow (E0 6B) is held
- mv_right  out  1  high while right arrow (E0 74) is held
- mv_down  out  1  high while down arrow (E0 72) is held
- mv_up  out  1  high while up arrow (E0 75) is held
- byte_valid  out  1  one-cycle pulse for each good received byte
- byte_data  out  8  last good byte; stable until the next byte_valid
- frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error

Behaviour:
- Reset values: all outputs 0; filtered ps2_clk = 1; receiver in RX_IDLE; decoder in D_IDLE.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through 2 flip-flops.
  - A counter filters the synchronised ps2_clk per FILTER_LEN.
  - A falling edge is a filtered 1→0 transition.
  - ps2_dat is sampled in the cycle the falling edge is detected.
- Receiver FSM:
  - RX_IDLE: on a falling edge, if data=0 go to RX_DATA with bit count 0. If data=1, pulse frame_err and stay in RX_IDLE.
  - RX_DATA: shift 8 bits LSB first on successive edges, then go to RX_PARITY.
  - RX_PARITY: capture the parity bit on the next edge, then go to RX_STOP.
  - RX_STOP: capture the stop bit on the next edge.
    - Success requires stop bit = 1 and odd parity over data plus parity bit.
    - On success: byte_valid=1 and byte_data updated in the cycle after the stop edge.
    - Otherwise frame_err=1 in that cycle, with byte_data unchanged.
    - Return to RX_IDLE in both cases.
- Timeout:
  - The timeout counter clears on every falling edge and counts only outside RX_IDLE.
  - On reaching TIMEOUT_CYCLES-1: pulse frame_err, return to RX_IDLE, force decoder to D_IDLE.
- Decoder FSM (advances only on byte_valid):
  - D_IDLE:
    - E0 → D_EXT.
    - F0 → D_BRK.
    - Any other byte → D_IDLE; non-extended makes are ignored.
  - D_EXT:
    - F0 → D_EXT_BRK.
    - Arrow code → set the matching mv_* to 1, then D_IDLE.
    - Other byte → D_IDLE.
  - D_EXT_BRK: arrow code → clear the matching mv_*; any byte → D_IDLE.
  - D_BRK: any byte → D_IDLE, with no output change.
- Output timing:
  - mv_* update exactly 1 cycle after the byte_valid that completes the sequence.
  - Total latency from the stop-bit edge is 2 clk cycles after detection.
- Simultaneous keys: each mv_* is independent, and several may be high at once. Priority between them belongs to the consumer.
- Typematic repeats of a make leave an already-set mv_* at 1.
- frame_err in mid-sequence forces the decoder to D_IDLE. Held mv_* keep their values.
- Reset mid-frame discards the partial byte and clears all mv_*.
- Keyboard-to-host only: ps2_clk and ps2_dat are never driven.

Test Plan:
- Send frame E0 (parity 0, stop 1), then frame 6B → byte_valid pulses twice with byte_data=E0 then 6B; mv_left=1 two cycles after the second stop edge; others 0.
- Send E0 F0 6B after the left press → mv_left returns to 0; no frame_err.
- Send E0 75, then E0 74, with both held → mv_up=1 and mv_right=1 together. Release E0 F0 75 → only mv_up drops.
- Send byte 72 with a corrupted parity bit → frame_err pulses once; no byte_valid; byte_data keeps its previous value; mv_down stays 0.
- Send 5 bits of a frame, then hold ps2_clk high for 50000 cycles → frame_err pulses at timeout; a following clean E0 72 sets mv_down=1.
- Hold mv_right=1, then assert reset mid-frame → all outputs 0 immediately; after release, a 1-cycle ps2_clk glitch shorter than FILTER_LEN causes no edge.

Source files
------------

// File: rtl/ps2_arrow_decoder.sv
// PS/2 keyboard receiver with arrow-key make/break tracking.
// Produces level-held direction signals for the game control FSM.
module ps2_arrow_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       mv_left,
  output logic       mv_right,
  output logic       mv_down,
  output logic       mv_up,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    RX_IDLE, RX_DATA, RX_PARITY, RX_STOP
  } rx_t;

  typedef enum logic [1:0] {
    D_IDLE, D_EXT, D_EXT_BRK, D_BRK
  } dec_t;

  logic [1:0]    ck_sync_q, dt_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          ck_s, dat, fall;

  rx_t           rx_q, rx_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout;

  logic          bv_q, bv_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    bdata_q, bdata_d;

  dec_t          dec_q, dec_d;
  logic [3:0]    mv_q, mv_d;

  // Map an extended scan code to {up, down, right, left}
  function automatic logic [3:0] arrow(input logic [7:0] c);
    logic [3:0] r;
    r = 4'b0000;
    unique case (c)
      8'h6B:   r = 4'b0001;
      8'h74:   r = 4'b0010;
      8'h72:   r = 4'b0100;
      8'h75:   r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  assign ck_s = ck_sync_q[1];
  assign dat  = dt_sync_q[1];

  // Two-flop synchronisers; idle PS/2 lines are high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ck_sync_q <= 2'b11;
      dt_sync_q <= 2'b11;
    end else begin
      ck_sync_q <= {ck_sync_q[0], ps2_clk};
      dt_sync_q <= {dt_sync_q[0], ps2_dat};
    end
  end

  // Glitch filter: level follows only after FILTER_LEN differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (ck_s != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = ck_s;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  // Timeout fires only mid-frame and never in an edge cycle
  assign timeout = (rx_q != RX_IDLE) && !fall &&
                   (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // State register for filter, receiver, decoder and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
      rx_q    <= RX_IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      timer_q <= '0;
      bv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      bdata_q <= '0;
      dec_q   <= D_IDLE;
      mv_q    <= '0;
    end else begin
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      rx_q    <= rx_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      timer_q <= timer_d;
      bv_q    <= bv_d;
      ferr_q  <= ferr_d;
      bdata_q <= bdata_d;
      dec_q   <= dec_d;
      mv_q    <= mv_d;
    end
  end

  // Receiver next state: shift data LSB first on filtered falling edges
  always_comb begin
    rx_d    = rx_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (fall || rx_q == RX_IDLE) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
    if (timeout) begin
      rx_d    = RX_IDLE;
      timer_d = '0;
    end else if (fall) begin
      unique case (rx_q)
        RX_IDLE: begin
          if (!dat) begin
            rx_d   = RX_DATA;
            bcnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d = {dat, shift_q[7:1]};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == 3'd7) rx_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d = dat;
          rx_d  = RX_STOP;
        end
        RX_STOP: rx_d = RX_IDLE;
      endcase
    end
  end

  // Receiver outputs: byte or error pulse in the cycle after the edge
  always_comb begin
    bv_d    = 1'b0;
    ferr_d  = timeout;
    bdata_d = bdata_q;
    if (fall) begin
      unique case (rx_q)
        RX_IDLE: ferr_d = dat;
        RX_STOP: begin
          if (dat && (^{shift_q, par_q})) begin
            bv_d    = 1'b1;
            bdata_d = shift_q;
          end else begin
            ferr_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Decoder next state: any frame error abandons a partial sequence
  always_comb begin
    dec_d = dec_q;
    if (ferr_q) begin
      dec_d = D_IDLE;
    end else if (bv_q) begin
      unique case (dec_q)
        D_IDLE: begin
          if (bdata_q == 8'hE0)      dec_d = D_EXT;
          else if (bdata_q == 8'hF0) dec_d = D_BRK;
          else                       dec_d = D_IDLE;
        end
        D_EXT: begin
          if (bdata_q == 8'hF0) dec_d = D_EXT_BRK;
          else                  dec_d = D_IDLE;
        end
        D_EXT_BRK: dec_d = D_IDLE;
        D_BRK:     dec_d = D_IDLE;
      endcase
    end
  end

  // Decoder outputs: extended make sets, extended break clears
  always_comb begin
    mv_d = mv_q;
    if (bv_q && !ferr_q) begin
      unique case (dec_q)
        D_EXT: begin
          if (bdata_q != 8'hF0) mv_d = mv_q | arrow(bdata_q);
        end
        D_EXT_BRK: mv_d = mv_q & ~arrow(bdata_q);
        default: ;
      endcase
    end
  end

  assign mv_left    = mv_q[0];
  assign mv_right   = mv_q[1];
  assign mv_down    = mv_q[2];
  assign mv_up      = mv_q[3];
  assign byte_valid = bv_q;
  assign byte_data  = bdata_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Self-checking bench for ps2_arrow_decoder.
// Bytes are scoreboarded; arrow state is checked from a vector table.
module tb_ps2_arrow_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       mv_left, mv_right, mv_down, mv_up;
  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  int tests = 0;
  int fails = 0;
  int ferr_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;

  typedef struct {
    logic [7:0] code;
    logic [3:0] mv;
  } vec_t;

  vec_t tbl[$];

  ps2_arrow_decoder #(
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(50000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .mv_left   (mv_left),
    .mv_right  (mv_right),
    .mv_down   (mv_down),
    .mv_up     (mv_up),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] mv_vec();
    return {mv_up, mv_down, mv_right, mv_left};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard and error-pulse monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (byte_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_byte: got %0h expected none",
                   byte_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (byte_data !== e) begin
            fails++;
            $display("FAIL byte_data: got %0h expected %0h",
                     byte_data, e);
          end
        end
      end
      if (frame_err) ferr_seen++;
    end
  end

  task automatic ps2_bit(input logic v);
    @(negedge clk);
    ps2_dat = v;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~(^b) ^ bad_par;
    if (!bad_par) begin
      exp_q.push_back(b);
      last_good = b;
    end
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int ferr0;
    int k;
    logic got;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mv", {28'd0, mv_vec()}, 32'd0);
    check("rst_bv", {31'd0, byte_valid}, 32'd0);
    check("rst_bd", {24'd0, byte_data}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Exact output latency relative to byte_valid
    send_frame(8'hE0, 1'b0);
    check("e0_mv", {28'd0, mv_vec()}, 32'd0);
    got = 1'b0;
    fork
      send_frame(8'h6B, 1'b0);
      begin
        for (k = 0; k < 400 && !got; k++) begin
          @(negedge clk);
          if (byte_valid) got = 1'b1;
        end
        check("bv_seen", {31'd0, got}, 32'd1);
        check("mv_before", {28'd0, mv_vec()}, 32'd0);
        @(negedge clk);
        check("bv_pulse", {31'd0, byte_valid}, 32'd0);
        check("mv_after", {28'd0, mv_vec()}, 32'h1);
      end
    join

    // Table of byte -> expected arrow state
    tbl = '{
      '{8'hE0, 4'b0001}, '{8'hF0, 4'b0001}, '{8'h6B, 4'b0000},
      '{8'hE0, 4'b0000}, '{8'h75, 4'b1000},
      '{8'hE0, 4'b1000}, '{8'h74, 4'b1010},
      '{8'hE0, 4'b1010}, '{8'hF0, 4'b1010}, '{8'h75, 4'b0010},
      '{8'hE0, 4'b0010}, '{8'h74, 4'b0010},
      '{8'h1C, 4'b0010}, '{8'hF0, 4'b0010}, '{8'h1C, 4'b0010},
      '{8'h75, 4'b0010},
      '{8'hE0, 4'b0010}, '{8'hF0, 4'b0010}, '{8'h74, 4'b0000}
    };
    ferr0 = ferr_seen;
    for (int i = 0; i < tbl.size(); i++) begin
      send_frame(tbl[i].code, 1'b0);
      check($sformatf("tbl%0d", i), {28'd0, mv_vec()},
            {28'd0, tbl[i].mv});
    end
    check("tbl_no_ferr", ferr_seen, ferr0);

    // Corrupted parity
    ferr0 = ferr_seen;
    send_frame(8'h72, 1'b1);
    check("par_ferr", ferr_seen, ferr0 + 1);
    check("par_bd", {24'd0, byte_data}, {24'd0, last_good});
    check("par_down", {31'd0, mv_down}, 32'd0);

    // Partial frame then timeout
    ferr0 = ferr_seen;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_dat = 1'b1;
    for (k = 0; k < 50200 && ferr_seen == ferr0; k++) @(negedge clk);
    check("timeout_ferr", ferr_seen, ferr0 + 1);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h72, 1'b0);
    check("to_down", {28'd0, mv_vec()}, 32'h4);

    // Reset mid-frame with right held
    send_frame(8'hE0, 1'b0);
    send_frame(8'h74, 1'b0);
    check("rr_held", {28'd0, mv_vec()}, 32'h6);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rr_mv", {28'd0, mv_vec()}, 32'd0);
    check("rr_bd", {24'd0, byte_data}, 32'd0);
    check("rr_flags", {30'd0, byte_valid, frame_err}, 32'd0);
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    last_good = 8'h00;
    repeat (10) @(negedge clk);

    // Short ps2_clk glitches must not produce an edge
    ferr0 = ferr_seen;
    ps2_clk = 1'b0;
    @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch1", ferr_seen, ferr0);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch3", ferr_seen, ferr0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h74, 1'b0);
    check("post_rst", {28'd0, mv_vec()}, 32'h2);
    check("post_ferr", ferr_seen, ferr0);

    repeat (5) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
